// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, one stop bit.
// Frame timing is derived from a clocks-per-bit counter; all outputs are registered.
module uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_serial,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t               state_r, state_s;
  logic [CNT_W-1:0]     cnt_r, cnt_s;
  logic [IDX_W-1:0]     idx_r, idx_s;
  logic [DATA_BITS-1:0] shift_r, shift_s;
  logic                 parity_r, parity_s;
  logic                 serial_s;
  logic                 done_s;
  logic                 bit_end_s;

  function automatic logic calc_parity(input logic [DATA_BITS-1:0] word);
    calc_parity = (PARITY_ODD != 0) ? ~(^word) : (^word);
  endfunction

  // Next-state, bit timer, shift register and next-output decode
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    idx_s     = idx_r;
    shift_s   = shift_r;
    parity_s  = parity_r;
    done_s    = 1'b0;
    serial_s  = 1'b1;
    bit_end_s = (cnt_r == CNT_LAST);

    if (state_r == IDLE) begin
      cnt_s = CNT_ZERO;
    end else if (bit_end_s) begin
      cnt_s = CNT_ZERO;
    end else begin
      cnt_s = cnt_r + CNT_W'(1'b1);
    end

    case (state_r)
      IDLE: begin
        if (tx_start) begin
          shift_s  = tx_data;
          parity_s = calc_parity(tx_data);
          idx_s    = IDX_ZERO;
          state_s  = START;
        end else begin
          state_s  = IDLE;
        end
      end
      START: begin
        if (bit_end_s) begin
          state_s = DATA;
        end else begin
          state_s = START;
        end
      end
      DATA: begin
        if (bit_end_s) begin
          shift_s = {1'b0, shift_r[DATA_BITS-1:1]};
          if (idx_r == IDX_LAST) begin
            idx_s   = IDX_ZERO;
            state_s = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            idx_s   = idx_r + IDX_W'(1'b1);
          end
        end else begin
          state_s = DATA;
        end
      end
      PARITY: begin
        if (bit_end_s) begin
          state_s = STOP;
        end else begin
          state_s = PARITY;
        end
      end
      STOP: begin
        if (bit_end_s) begin
          state_s = IDLE;
          done_s  = 1'b1;
        end else begin
          state_s = STOP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    // Line level is decoded from the next state so it can be registered
    case (state_s)
      IDLE:    serial_s = 1'b1;
      START:   serial_s = 1'b0;
      DATA:    serial_s = shift_s[0];
      PARITY:  serial_s = parity_s;
      STOP:    serial_s = 1'b1;
      default: serial_s = 1'b1;
    endcase
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      cnt_r     <= CNT_ZERO;
      idx_r     <= IDX_ZERO;
      shift_r   <= {DATA_BITS{1'b0}};
      parity_r  <= 1'b0;
      tx_serial <= 1'b1;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      idx_r     <= idx_s;
      shift_r   <= shift_s;
      parity_r  <= parity_s;
      tx_serial <= serial_s;
      tx_busy   <= (state_s != IDLE);
      tx_done   <= done_s;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: table of directed frames over four parameter
// sets, plus hand-written back-to-back, busy-rejection and mid-frame reset sequences.
module tb_uart_tx;

  logic       clk;
  logic       reset;
  logic [3:0] start_v;
  logic [8:0] data_v [4];
  wire  [3:0] ser_w;
  wire  [3:0] busy_w;
  wire  [3:0] done_w;

  int tests = 0;
  int fails = 0;

  // 0: baseline 434/8, 1: even parity, 2: odd parity, 3: minimum divisor 2/5
  uart_tx #(.CLKS_PER_BIT(434), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) u0 (
    .clk(clk), .reset(reset), .tx_start(start_v[0]), .tx_data(data_v[0][7:0]),
    .tx_serial(ser_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0]));
  uart_tx #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) u1 (
    .clk(clk), .reset(reset), .tx_start(start_v[1]), .tx_data(data_v[1][7:0]),
    .tx_serial(ser_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1]));
  uart_tx #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1)) u2 (
    .clk(clk), .reset(reset), .tx_start(start_v[2]), .tx_data(data_v[2][7:0]),
    .tx_serial(ser_w[2]), .tx_busy(busy_w[2]), .tx_done(done_w[2]));
  uart_tx #(.CLKS_PER_BIT(2), .DATA_BITS(5), .PARITY_EN(0), .PARITY_ODD(0)) u3 (
    .clk(clk), .reset(reset), .tx_start(start_v[3]), .tx_data(data_v[3][4:0]),
    .tx_serial(ser_w[3]), .tx_busy(busy_w[3]), .tx_done(done_w[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          which;
    logic [8:0]  data;
    int          cpb;
    int          nbits;
    logic [10:0] exp;
    string       name;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Start a frame in the current cycle and follow it through its tx_done cycle.
  task automatic run_frame(input int which, input logic [8:0] data, input int cpb,
                           input int nbits, input logic [10:0] exp, input string name,
                           input int inject_at);
    int          f;
    int          busy_cnt;
    int          done_cnt;
    int          done_at;
    int          cyc_err;
    logic [10:0] got;
    logic        idle_after;
    f          = nbits * cpb;
    busy_cnt   = 0;
    done_cnt   = 0;
    done_at    = -1;
    cyc_err    = 0;
    got        = 11'h000;
    idle_after = 1'b0;
    start_v[which] = 1'b1;
    data_v[which]  = data;
    tick();
    start_v[which] = 1'b0;
    data_v[which]  = ~data;
    for (int c = 1; c <= f + 1; c++) begin
      if (c == inject_at) begin
        start_v[which] = 1'b1;
        data_v[which]  = 9'h1FF;
      end else if (c == inject_at + 1) begin
        start_v[which] = 1'b0;
      end
      if (busy_w[which] === 1'b1) busy_cnt++;
      if (done_w[which] === 1'b1) begin
        done_cnt++;
        done_at = c;
      end
      if (c <= f) begin
        if (ser_w[which] !== exp[(c - 1) / cpb]) cyc_err++;
        if (((c - 1) % cpb) == (cpb / 2)) got[(c - 1) / cpb] = ser_w[which];
        tick();
      end else begin
        idle_after = ser_w[which];
      end
    end
    check({name, "_bits"}, 32'(got), 32'(exp));
    check({name, "_cycles_wrong"}, 32'(cyc_err), 32'd0);
    check({name, "_busy_len"}, 32'(busy_cnt), 32'(f));
    check({name, "_done_count"}, 32'(done_cnt), 32'd1);
    check({name, "_done_at"}, 32'(done_at), 32'(f + 1));
    check({name, "_idle_after"}, 32'(idle_after), 32'd1);
  endtask

  vec_t vecs [6];

  initial begin
    int idle_err;

    // Frame bit i of exp is line level during bit i (bit 0 = start bit)
    vecs[0] = '{0, 9'h0A5, 434, 10, 11'h34A, "a5_434"};
    vecs[1] = '{1, 9'h007,  16, 11, 11'h60E, "par_even_07"};
    vecs[2] = '{2, 9'h007,  16, 11, 11'h40E, "par_odd_07"};
    vecs[3] = '{1, 9'h000,  16, 11, 11'h400, "par_even_00"};
    vecs[4] = '{2, 9'h000,  16, 11, 11'h600, "par_odd_00"};
    vecs[5] = '{3, 9'h01A,   2,  7, 11'h074, "min_div_1a"};

    reset   = 1'b0;
    start_v = 4'b0000;
    for (int i = 0; i < 4; i++) data_v[i] = 9'h000;
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("reset_state_%0d", i), {29'd0, ser_w[i], busy_w[i], done_w[i]}, 32'd4);
    end
    reset = 1'b1;
    tick();
    tick();

    for (int v = 0; v < 6; v++) begin
      tick();
      run_frame(vecs[v].which, vecs[v].data, vecs[v].cpb, vecs[v].nbits,
                vecs[v].exp, vecs[v].name, -1);
    end

    // Back-to-back: second strobe lands in the first frame's tx_done cycle
    tick();
    run_frame(0, 9'h055, 434, 10, 11'h2AA, "b2b_first", -1);
    run_frame(0, 9'h00F, 434, 10, 11'h21E, "b2b_second", -1);

    // Busy rejection: 0xFF request at cycle 1000 of a 0x00 frame
    tick();
    run_frame(0, 9'h000, 434, 10, 11'h200, "busy_reject", 1000);
    idle_err = 0;
    for (int c = 0; c < 3 * 434; c++) begin
      tick();
      if (ser_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || done_w[0] !== 1'b0) idle_err++;
    end
    check("busy_reject_no_second_frame", 32'(idle_err), 32'd0);

    // Reset during data bit 3 of 0x3C (bit 3 spans cycles 1737..2170)
    start_v[0] = 1'b1;
    data_v[0]  = 9'h03C;
    tick();
    start_v[0] = 1'b0;
    repeat (1936 - 1) tick();
    check("rst_pre_busy", 32'(busy_w[0]), 32'd1);
    check("rst_pre_bit3", 32'(ser_w[0]), 32'd1);
    reset = 1'b0;
    #2;
    check("rst_async_outputs", {29'd0, ser_w[0], busy_w[0], done_w[0]}, 32'd4);
    tick();
    tick();
    reset = 1'b1;
    idle_err = 0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (ser_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || done_w[0] !== 1'b0) idle_err++;
    end
    check("rst_no_resume", 32'(idle_err), 32'd0);
    tick();
    run_frame(0, 9'h03C, 434, 10, 11'h278, "after_reset_3c", -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Parameterized UART transmitter that serializes one parallel data word per request into an asynchronous frame: start bit, LSB-first data, optional parity, one stop bit. It is the transmit-side counterpart of the team's baud-rate counter and receiver path, and uses the same clocks-per-bit timing base (434 clocks per bit at 50 MHz for 115200 baud). It sits between a byte-producing controller and the serial line pin, with a single-cycle start strobe and busy/done status.

## Interface
- CLKS_PER_BIT, 434: clock cycles per serial bit; legal range ≥ 2.
- DATA_BITS, 8: data bits per frame; legal range 5..9.
- PARITY_EN, 0: 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0: 0 selects even parity, 1 selects odd parity; ignored when PARITY_EN=0.
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- tx_start  input  1  request strobe; sampled only while tx_busy=0.
- tx_data  input  DATA_BITS  word to send; captured in the accept cycle.
- tx_serial  output  1  serial line; registered; idles high.
- tx_busy  output  1  high from the cycle after accept until the frame completes.
- tx_done  output  1  one-cycle pulse at frame completion.

## Operation
- The FSM has five states: IDLE, START, DATA, PARITY, STOP.
- **IDLE**
  - tx_serial=1, tx_busy=0.
  - On tx_start=1: capture tx_data into a shift register, compute parity from the captured word, clear the bit counter, go to START.
- **START**
  - tx_serial=0 for CLKS_PER_BIT cycles, then go to DATA.
- **DATA**
  - Drive shift_reg[0] for CLKS_PER_BIT cycles, then shift right.
  - Repeat DATA_BITS times, using a data-bit index 0..DATA_BITS-1.
  - After the last bit, go to PARITY if PARITY_EN=1, otherwise go to STOP.
- **PARITY**
  - Drive the parity bit for CLKS_PER_BIT cycles, then go to STOP.
  - Parity bit = XOR of the data bits, inverted when PARITY_ODD=1.
- **STOP**
  - tx_serial=1 for CLKS_PER_BIT cycles, then go to IDLE and pulse tx_done.
- **Bit timer**
  - Width is ceil(log2(CLKS_PER_BIT)) bits.
  - Counts 0..CLKS_PER_BIT-1, wraps to 0 at the end of each bit, and is held at 0 in IDLE.
  - The end-of-bit condition is a compare against CLKS_PER_BIT-1.
- **Input isolation**
  - tx_start while tx_busy=1 is ignored. It is not queued.
  - tx_data changes after the accept cycle have no effect on the frame in flight.
- **Reset**
  - On assertion, at any time, including mid-frame: state=IDLE, tx_serial=1, tx_busy=0, tx_done=0, and all counters and the shift register are 0.
  - No partial frame resumes after reset is released.

## Timing
- Accept cycle: tx_start=1 sampled at rising edge N with tx_busy=0.
- From edge N+1:
  - tx_serial=0 and tx_busy=1.
  - The start bit occupies edges N+1..N+CLKS_PER_BIT.
- Data bit k begins at edge N+1+(1+k)·CLKS_PER_BIT.
- Frame length F = (2 + DATA_BITS + PARITY_EN)·CLKS_PER_BIT cycles.
- At edge N+1+F:
  - tx_busy=0, tx_done=1 for exactly one cycle, and tx_serial=1.
- Back-to-back frames:
  - tx_start=1 in the tx_done cycle is accepted, since tx_busy=0.
  - The next start bit begins one cycle later, so exactly one idle-high cycle separates the frames.
- tx_start held high continuously produces consecutive frames with that same one-cycle gap.
- All outputs are registered; no combinational path runs from any input to any output.

## Test plan
- **Single frame:** reset, then tx_data=0xA5, tx_start for 1 cycle, CLKS_PER_BIT=434.
  - tx_serial, sampled mid-bit, reads 0,1,0,1,0,0,1,0,1,1.
  - tx_busy is high for exactly 4340 cycles.
  - tx_done pulses once, 4341 cycles after accept.
- **Back-to-back:** 0x55 then 0x0F, with the second tx_start asserted in the first frame's tx_done cycle.
  - Both frames are correct.
  - A single idle-high cycle separates the first stop bit and the second start bit.
- **Busy rejection:** tx_start with 0xFF asserted at cycle 1000 of a 0x00 frame.
  - The frame stays all-zero data.
  - There is exactly one tx_done.
  - No second frame follows.
- **Parity:** PARITY_EN=1 with 0x07.
  - With PARITY_ODD=0, the parity bit is 1.
  - With PARITY_ODD=1, the parity bit is 0.
  - F = 11·CLKS_PER_BIT.
- **Reset mid-frame:** assert reset during data bit 3 of 0x3C.
  - tx_serial=1, tx_busy=0, and tx_done=0 immediately, asynchronously.
  - After release, the line stays high until a new tx_start.
- **Minimum divisor:** CLKS_PER_BIT=2, DATA_BITS=5, data 0x1A.
  - Each bit lasts exactly 2 cycles.
  - The frame is 0,0,1,0,1,1,1 (start, LSB-first data, stop).
  - F = 14 cycles.
